// File: rtl/quiz_pkg.sv
// ---------------------------------------------------------------------------
// quiz_pkg
// Shared definitions for the quiz round sequencer:
//   - state_e    : sequencer states (IDLE, SHOW, ANSWER, RESULT)
//   - default prescaler and round timing constants
//   - SCORE_MAX  : saturation limit of the score counter
// ---------------------------------------------------------------------------
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    ANSWER = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int CLK_DIV_DEF     = 5;   // clk_in cycles per tick
  localparam int SHOW_TICKS_DEF  = 3;   // ticks the question stays on screen
  localparam int ROUND_TICKS_DEF = 10;  // ticks allowed for an answer
  localparam int DIV_W_DEF       = 4;   // prescaler counter width

  localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage : quiz_pkg

// File: rtl/quiz_round_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// quiz_tick_gen
// Prescaler turning clk_in into a one-cycle tick every CLK_DIV cycles.
// Ports:
//   clk_in   system clock
//   reset_n  asynchronous active-low reset
//   run      counting enabled; while low the counter is held at 0
//   clear    synchronous clear of the counter (restarts the tick phase)
//   tick     high for the cycle in which the counter sits at CLK_DIV-1
// ---------------------------------------------------------------------------
module quiz_tick_gen #(
  parameter int CLK_DIV = 5,
  parameter int DIV_W   = 4
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!run || clear) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // Decode of registered state only, so tick is glitch-free and drops in IDLE.
  assign tick = run && (div_cnt_q == CNT_LAST);

endmodule : quiz_tick_gen

// File: rtl/quiz_round_sequencer.sv
// ---------------------------------------------------------------------------
// quiz_round_sequencer
// Runs one quiz round: question display window (SHOW), answer window with a
// countdown (ANSWER), then a one-cycle result pulse (RESULT).
// Ports:
//   clk_in, reset_n          clock, asynchronous active-low reset
//   start                    begin a round (only honoured in IDLE)
//   abort                    return to IDLE from any state, no result
//   answer_valid             player answer strobe (only honoured in ANSWER)
//   answer_correct           correctness of the answer, qualified by answer_valid
//   tick                     prescaler pulse, only outside IDLE
//   show_en / answer_en      state decodes for SHOW / ANSWER
//   time_left                remaining answer ticks
//   round_done               one-cycle pulse while in RESULT
//   timed_out, last_correct  outcome of the last round
//   score                    saturating count of correct answers
// ---------------------------------------------------------------------------
module quiz_round_sequencer
  import quiz_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int SHOW_TICKS  = SHOW_TICKS_DEF,
  parameter int ROUND_TICKS = ROUND_TICKS_DEF,
  parameter int DIV_W       = DIV_W_DEF
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       answer_valid,
  input  logic       answer_correct,
  output logic       tick,
  output logic       show_en,
  output logic       answer_en,
  output logic [7:0] time_left,
  output logic       round_done,
  output logic       timed_out,
  output logic       last_correct,
  output logic [7:0] score
);

  localparam logic [7:0] SHOW_LAST  = 8'(SHOW_TICKS - 1);
  localparam logic [7:0] ROUND_LOAD = 8'(ROUND_TICKS);

  state_e     state_q, state_d;
  logic [7:0] show_cnt_q, show_cnt_d;
  logic [7:0] time_left_q, time_left_d;
  logic       timed_out_q, timed_out_d;
  logic       last_correct_q, last_correct_d;
  logic [7:0] score_q, score_d;

  logic tick_w;
  logic div_run;
  logic div_clear;

  // The prescaler only runs during a round; restarting it on start makes the
  // first tick land exactly CLK_DIV cycles later, and abort kills the phase.
  assign div_run   = (state_q != IDLE);
  assign div_clear = abort || ((state_q == IDLE) && start);

  quiz_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick_gen (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .run     (div_run),
    .clear   (div_clear),
    .tick    (tick_w)
  );

  always_comb begin
    state_d        = state_q;
    show_cnt_d     = show_cnt_q;
    time_left_d    = time_left_q;
    timed_out_d    = timed_out_q;
    last_correct_d = last_correct_q;
    score_d        = score_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d        = SHOW;
            show_cnt_d     = '0;
            timed_out_d    = 1'b0;
            last_correct_d = 1'b0;
          end
        end

        SHOW: begin
          if (tick_w) begin
            if (show_cnt_q == SHOW_LAST) begin
              state_d     = ANSWER;
              time_left_d = ROUND_LOAD;
            end else begin
              show_cnt_d = show_cnt_q + 8'd1;
            end
          end
        end

        ANSWER: begin
          // An answer beats a coinciding final tick: no timeout, no decrement.
          if (answer_valid) begin
            state_d        = RESULT;
            last_correct_d = answer_correct;
            if (answer_correct && (score_q != SCORE_MAX)) begin
              score_d = score_q + 8'd1;
            end
          end else if (tick_w) begin
            // <= 1 rather than == 1 keeps time_left from ever wrapping below 0.
            if (time_left_q <= 8'd1) begin
              time_left_d = '0;
              timed_out_d = 1'b1;
              state_d     = RESULT;
            end else begin
              time_left_d = time_left_q - 8'd1;
            end
          end
        end

        RESULT: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      show_cnt_q     <= '0;
      time_left_q    <= '0;
      timed_out_q    <= 1'b0;
      last_correct_q <= 1'b0;
      score_q        <= '0;
    end else begin
      state_q        <= state_d;
      show_cnt_q     <= show_cnt_d;
      time_left_q    <= time_left_d;
      timed_out_q    <= timed_out_d;
      last_correct_q <= last_correct_d;
      score_q        <= score_d;
    end
  end

  // round_done decodes the registered state, so an abort sampled during
  // RESULT cannot suppress the pulse already on the wire.
  assign tick         = tick_w;
  assign show_en      = (state_q == SHOW);
  assign answer_en    = (state_q == ANSWER);
  assign round_done   = (state_q == RESULT);
  assign time_left    = time_left_q;
  assign timed_out    = timed_out_q;
  assign last_correct = last_correct_q;
  assign score        = score_q;

endmodule : quiz_round_sequencer

// File: tb/tb_quiz_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_quiz_round_sequencer
// Directed bench for quiz_round_sequencer (CLK_DIV=5, SHOW_TICKS=3,
// ROUND_TICKS=10). Round outcomes are queued when a round is stimulated and
// checked by a monitor on every round_done pulse; timing and state checks
// go through check().
// ---------------------------------------------------------------------------
module tb_quiz_round_sequencer;

  typedef struct packed {
    logic       to;
    logic       lc;
    logic [7:0] tl;
    logic [7:0] sc;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       answer_valid;
  logic       answer_correct;
  logic       tick;
  logic       show_en;
  logic       answer_en;
  logic [7:0] time_left;
  logic       round_done;
  logic       timed_out;
  logic       last_correct;
  logic [7:0] score;

  int   n_cmp  = 0;
  int   n_err  = 0;
  int   rd_cnt = 0;
  exp_t exp_q[$];

  logic [21:0] all_outs;
  assign all_outs = {tick, show_en, answer_en, time_left, round_done,
                     timed_out, last_correct, score};

  quiz_round_sequencer #(
    .CLK_DIV     (5),
    .SHOW_TICKS  (3),
    .ROUND_TICKS (10),
    .DIV_W       (4)
  ) dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .tick           (tick),
    .show_en        (show_en),
    .answer_en      (answer_en),
    .time_left      (time_left),
    .round_done     (round_done),
    .timed_out      (timed_out),
    .last_correct   (last_correct),
    .score          (score)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Scoreboard monitor: every round_done pulse consumes one queued outcome.
  always @(negedge clk_in) begin
    if (reset_n && round_done) begin
      exp_t e;
      rd_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL round_result: unexpected round_done (to=%0b lc=%0b tl=%0d sc=%0d), none expected",
                 timed_out, last_correct, time_left, score);
      end else begin
        e = exp_q.pop_front();
        if ({timed_out, last_correct, time_left, score} !== e) begin
          n_err++;
          $display("FAIL round_result: got to=%0b lc=%0b tl=%0d sc=%0d, want to=%0b lc=%0b tl=%0d sc=%0d",
                   timed_out, last_correct, time_left, score, e.to, e.lc, e.tl, e.sc);
        end
      end
    end
  end

  function automatic exp_t mk(input logic to, input logic lc, input int tl, input int sc);
    exp_t e;
    e.to = to;
    e.lc = lc;
    e.tl = 8'(tl);
    e.sc = 8'(sc);
    return e;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_show(output int n);
    n = 0;
    while (show_en && n < 100) begin
      cycle();
      n++;
    end
  endtask

  // Waits until k ticks have been consumed by the DUT; n = cycles spent.
  task automatic wait_ticks(input int k, output int n);
    int seen;
    seen = 0;
    n    = 0;
    while (seen < k && n < 200) begin
      if (tick) seen++;
      cycle();
      n++;
    end
    if (seen < k) check("tick_wait_bound", 32'(seen), 32'(k));
  endtask

  task automatic count_ticks(input int cycles, output int t);
    t = 0;
    for (int i = 0; i < cycles; i++) begin
      if (tick) t++;
      cycle();
    end
  endtask

  task automatic give_answer(input logic correct, input exp_t e);
    answer_valid   = 1'b1;
    answer_correct = correct;
    exp_q.push_back(e);
    cycle();
    answer_valid   = 1'b0;
    answer_correct = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int rd0;

    reset_n        = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    answer_valid   = 1'b0;
    answer_correct = 1'b0;
    repeat (3) cycle();
    check("reset_outputs", 32'(all_outs), 32'd0);
    reset_n = 1'b1;
    cycle();

    // Correct answer after the 4th answer tick.
    do_start();
    wait_show(n);
    check("show_len", 32'(n), 32'd15);
    check("answer_open", 32'(answer_en), 32'd1);
    check("time_left_load", 32'(time_left), 32'd10);
    wait_ticks(4, n);
    check("time_left_after_4", 32'(time_left), 32'd6);
    cycle();
    cycle();
    give_answer(1'b1, mk(1'b0, 1'b1, 6, 1));
    cycle();
    check("idle_after_result", 32'({show_en, answer_en, round_done}), 32'd0);

    // Timeout: nobody answers.
    do_start();
    exp_q.push_back(mk(1'b1, 1'b0, 0, 1));
    wait_show(n);
    n = 0;
    while (answer_en && n < 200) begin
      cycle();
      n++;
    end
    check("answer_len_timeout", 32'(n), 32'd50);
    cycle();
    check("score_after_timeout", 32'(score), 32'd1);

    // Wrong answer coinciding with the final tick: the answer wins.
    do_start();
    wait_show(n);
    wait_ticks(9, n);
    check("time_left_before_final", 32'(time_left), 32'd1);
    n = 0;
    while (!tick && n < 20) begin
      cycle();
      n++;
    end
    check("final_tick_present", 32'(tick), 32'd1);
    give_answer(1'b0, mk(1'b0, 1'b0, 1, 1));
    cycle();
    check("time_left_holds", 32'(time_left), 32'd1);

    // Abort during SHOW.
    rd0 = rd_cnt;
    do_start();
    repeat (7) cycle();
    check("in_show_before_abort", 32'(show_en), 32'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_to_idle", 32'({show_en, answer_en}), 32'd0);
    count_ticks(20, t);
    check("no_tick_after_abort", 32'(t), 32'd0);

    // start during ANSWER is ignored and does not disturb the tick phase.
    do_start();
    wait_show(n);
    wait_ticks(2, n);
    check("time_left_after_2", 32'(time_left), 32'd8);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_ignored_state", 32'(answer_en), 32'd1);
    check("start_ignored_tl", 32'(time_left), 32'd8);
    wait_ticks(1, n);
    check("tick_cadence_kept", 32'(n), 32'd4);
    check("time_left_after_3", 32'(time_left), 32'd7);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
    check("no_round_done_on_abort", 32'(rd_cnt), 32'(rd0));
    check("score_after_aborts", 32'(score), 32'd1);

    // Asynchronous reset in the middle of ANSWER.
    do_start();
    wait_show(n);
    wait_ticks(4, n);
    check("time_left_before_reset", 32'(time_left), 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(all_outs), 32'd0);
    repeat (2) cycle();
    reset_n = 1'b1;
    count_ticks(20, t);
    check("no_tick_after_reset", 32'(t), 32'd0);
    check("idle_after_reset", 32'({show_en, answer_en}), 32'd0);

    // Saturation: 256 correct rounds from a zero score.
    for (int i = 0; i < 256; i++) begin
      do_start();
      wait_show(n);
      give_answer(1'b1, mk(1'b0, 1'b1, 10, (i + 1 > 255) ? 255 : i + 1));
      cycle();
    end
    check("score_saturated", 32'(score), 32'd255);

    repeat (3) cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_quiz_round_sequencer

// File: doc/quiz_round_sequencer.md
Name: quiz_round_sequencer

Overview:
- Sequences one quiz round for the speed mental-conversion game: a question display window, then an answer window with a countdown, then a result pulse.
- Owns an internal prescaler that turns clk_in into a slow tick enable. Only the sequencer starts, clears and stops that prescaler.
- Sits between the game top level (start, abort, answer inputs) and the display/score logic.

Parameters:
- CLK_DIV, 5, clk_in cycles per tick (must be 2 or more).
- SHOW_TICKS, 3, ticks the question is shown before answering opens (1 or more).
- ROUND_TICKS, 10, ticks allowed for an answer (1 to 255).
- DIV_W, 4, prescaler counter width (2^DIV_W must be at least CLK_DIV).

Ports:
- clk_in  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a round; honoured only in IDLE
- abort  in  1  return to IDLE from any state; no result is issued
- answer_valid  in  1  one-cycle strobe: the player submitted an answer
- answer_correct  in  1  correctness of the answer; qualified by answer_valid
- tick  out  1  one-cycle prescaler pulse; only active outside IDLE
- show_en  out  1  high while in SHOW
- answer_en  out  1  high while in ANSWER
- time_left  out  8  remaining answer ticks
- round_done  out  1  one-cycle pulse in RESULT
- timed_out  out  1  registered flag for the last round; valid from round_done onward
- last_correct  out  1  registered flag for the last round; valid from round_done onward
- score  out  8  saturating count of correct answers

Behaviour:

Reset (reset_n low, asynchronous):
- State goes to IDLE and the prescaler to 0.
- Every output goes to 0: tick, show_en, answer_en, time_left, round_done, timed_out, last_correct, score.

Prescaler:
- div_cnt counts 0 to CLK_DIV-1 and wraps.
- tick is high for the single cycle in which div_cnt equals CLK_DIV-1, when the state is not IDLE.
- div_cnt is held at 0 in IDLE and is cleared to 0 on the IDLE-to-SHOW transition.
- As a result, the first tick comes exactly CLK_DIV cycles after start is sampled.

State machine: IDLE, SHOW, ANSWER, RESULT.
- IDLE:
  - start and not abort: go to SHOW, clear show_cnt to 0, clear timed_out and last_correct.
  - start while not in IDLE is ignored.
- SHOW:
  - show_cnt increments on each tick.
  - On the tick where show_cnt equals SHOW_TICKS-1, go to ANSWER and load time_left with ROUND_TICKS.
- ANSWER, in priority order:
  - answer_valid: go to RESULT. Capture last_correct from answer_correct. If correct and score is below 255, increment score.
  - Else on a tick: decrement time_left. If the pre-decrement value is 1, time_left becomes 0, timed_out is set to 1, and the state goes to RESULT.
  - If answer_valid and the final tick fall in the same cycle, the answer wins: timed_out stays 0 and time_left is not decremented.
- RESULT:
  - round_done is high for this one cycle, then the state returns to IDLE unconditionally.
  - time_left holds its value until the next ANSWER load.
- abort:
  - Highest priority in every state. The next state is IDLE and the prescaler clears.
  - round_done is not pulsed and score is unchanged.
  - Abort in the RESULT cycle still lets that round_done pulse show, because it is already registered.
- answer_valid outside ANSWER is ignored.

Output timing:
- All outputs are registered.
- show_en and answer_en decode the current state.

Width rules:
- time_left is never decremented below 0.
- score saturates at 255; no wrap.

Decomposition:
- Shared package quiz_pkg holds:
  - the state enum (IDLE=2'd0, SHOW=2'd1, ANSWER=2'd2, RESULT=2'd3);
  - the default CLK_DIV, SHOW_TICKS and ROUND_TICKS constants;
  - SCORE_MAX = 8'd255.
- One sub-module, quiz_tick_gen: the prescaler, with ports clk_in, reset_n, run, clear, tick. The sequencer drives run as "state not IDLE" and pulses clear on start or abort.

Test Plan (all with CLK_DIV=5, SHOW_TICKS=3, ROUND_TICKS=10):
- Reset mid-round: assert reset_n low during ANSWER with time_left=6 -> state IDLE, all outputs 0 immediately (asynchronous), no tick afterwards.
- Correct answer: start, then answer_valid=1 with answer_correct=1 on the 4th answer tick -> SHOW lasts 15 cycles, round_done pulses once, last_correct=1, timed_out=0, time_left=6, score goes 0 to 1.
- Timeout: start, no answer -> time_left counts 10 down to 0 over 50 cycles, timed_out=1, one round_done pulse, score unchanged.
- Collision: answer_valid=1 with answer_correct=0 in the same cycle as the final tick (time_left=1) -> timed_out=0, last_correct=0, time_left stays 1.
- Abort and ignored start: abort during SHOW -> IDLE, no round_done, tick stops. start pulsed during ANSWER -> no effect on time_left or state.
- Saturation: 256 correct rounds -> score ends at 255, and the 256th round still pulses round_done.
